series_controller: RTL and testbench

- Moore FSM that sequences the series-evaluation datapath: x register, LUT-addressing counter, x/coefficient mux, multiplier, term register and result accumulator.
- Sits directly upstream of the datapath and drives all of its control inputs.
- Consumes the datapath's counter terminal-count flag `co`.
- Provides a start/busy/done handshake to the surrounding system.
- Runs a watchdog on the iteration count.

---
 rtl/series_pkg.sv | 92 +++++++++
 rtl/iter_watchdog.sv | 37 +++
 rtl/series_controller.sv | 108 ++++++++++
 tb/tb_series_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/series_pkg.sv
// ---------------------------------------------------------------------------
// series_pkg: shared state encoding, control bundle and decode. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package series_pkg;

  localparam int DEFAULT_TERM_LIMIT = 16;
  localparam int DEFAULT_ITER_W     = 8;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] MULX  = 3'd2;
  localparam logic [2:0] MULC  = 3'd3;
  localparam logic [2:0] ACC   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ABORT = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = IDLE,
    S_LOAD  = LOAD,
    S_MULX  = MULX,
    S_MULC  = MULC,
    S_ACC   = ACC,
    S_DONE  = DONE,
    S_ABORT = ABORT
  } state_t;

  typedef struct packed {
    logic zx;
    logic initx;
    logic ldx;
    logic zt;
    logic initt;
    logic ldt;
    logic zr;
    logic initr;
    logic ldr;
    logic zc;
    logic ldc;
    logic enc;
    logic s0;
    logic busy;
    logic done;
  } ctrl_t;

  // Pure Moore decode; any code outside the enum yields an all-zero bundle.
  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_LOAD: begin
        c.ldx   = 1'b1;
        c.initt = 1'b1;
        c.initr = 1'b1;
        c.zc    = 1'b1;
        c.busy  = 1'b1;
      end
      S_MULX: begin
        c.s0   = 1'b0;
        c.ldt  = 1'b1;
        c.busy = 1'b1;
      end
      S_MULC: begin
        c.s0   = 1'b1;
        c.ldt  = 1'b1;
        c.busy = 1'b1;
      end
      S_ACC: begin
        c.ldr  = 1'b1;
        c.enc  = 1'b1;
        c.busy = 1'b1;
      end
      S_DONE: begin
        c.done = 1'b1;
        c.busy = 1'b1;
      end
      S_ABORT: begin
        c.zx   = 1'b1;
        c.zt   = 1'b1;
        c.zr   = 1'b1;
        c.zc   = 1'b1;
        c.busy = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iter_watchdog.sv
// ---------------------------------------------------------------------------
// iter_watchdog: ACC iteration counter with terminal-limit flag. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module iter_watchdog
  import series_pkg::*;
#(
  parameter int TERM_LIMIT = DEFAULT_TERM_LIMIT,
  parameter int ITER_W     = DEFAULT_ITER_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic limit_hit
);

  localparam logic [ITER_W-1:0] ONE  = ITER_W'(1);
  // count + 1 == TERM_LIMIT is the same as count == TERM_LIMIT - 1 without widening.
  localparam logic [ITER_W-1:0] LAST = ITER_W'(TERM_LIMIT - 1);

  logic [ITER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + ONE;
    end
  end

  assign limit_hit = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/series_controller.sv
// ---------------------------------------------------------------------------
// series_controller: Moore sequencer for the series-evaluation datapath. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module series_controller
  import series_pkg::*;
#(
  parameter int TERM_LIMIT = DEFAULT_TERM_LIMIT,
  parameter int ITER_W     = DEFAULT_ITER_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic co,
  output logic zx,
  output logic initx,
  output logic ldx,
  output logic zt,
  output logic initt,
  output logic ldt,
  output logic zr,
  output logic initr,
  output logic ldr,
  output logic zc,
  output logic ldc,
  output logic enc,
  output logic s0,
  output logic busy,
  output logic done,
  output logic err
);

  state_t state;
  ctrl_t  ctrl;
  logic   limit_hit;
  logic   wd_clr;
  logic   wd_inc;

  assign wd_clr = (state == S_LOAD);
  assign wd_inc = (state == S_ACC);

  iter_watchdog #(
    .TERM_LIMIT (TERM_LIMIT),
    .ITER_W     (ITER_W)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr       (wd_clr),
    .inc       (wd_inc),
    .limit_hit (limit_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            err   <= 1'b0;
          end
        end
        S_LOAD: state <= S_MULX;
        S_MULX: state <= S_MULC;
        S_MULC: state <= S_ACC;
        S_ACC: begin
          // Terminal count wins over the watchdog when both land together.
          if (co) begin
            state <= S_DONE;
          end else if (limit_hit) begin
            state <= S_ABORT;
          end else begin
            state <= S_MULX;
          end
        end
        S_DONE: state <= S_IDLE;
        S_ABORT: begin
          state <= S_IDLE;
          err   <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ctrl  = decode(state);
  assign zx    = ctrl.zx;
  assign initx = ctrl.initx;
  assign ldx   = ctrl.ldx;
  assign zt    = ctrl.zt;
  assign initt = ctrl.initt;
  assign ldt   = ctrl.ldt;
  assign zr    = ctrl.zr;
  assign initr = ctrl.initr;
  assign ldr   = ctrl.ldr;
  assign zc    = ctrl.zc;
  assign ldc   = ctrl.ldc;
  assign enc   = ctrl.enc;
  assign s0    = ctrl.s0;
  assign busy  = ctrl.busy;
  assign done  = ctrl.done;

endmodule

`default_nettype wire

// File: tb/tb_series_controller.sv
// ---------------------------------------------------------------------------
// tb_series_controller: two DUTs (limit 16 and 4) against a run-offset model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_series_controller;

  localparam int B_ZX = 15, B_INITX = 14, B_LDX = 13, B_ZT = 12, B_INITT = 11;
  localparam int B_LDT = 10, B_ZR = 9, B_INITR = 8, B_LDR = 7, B_ZC = 6;
  localparam int B_LDC = 5, B_ENC = 4, B_S0 = 3, B_BUSY = 2, B_DONE = 1, B_ERR = 0;

  int lim [2] = '{16, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start [2] = '{1'b0, 1'b0};
  logic co [2];
  logic rnd_co [2] = '{1'b0, 1'b0};
  int   co_mode [2] = '{0, 1};  // 0: datapath counter hits 15, 1: never, 2: random
  logic [3:0] adr [2] = '{4'd0, 4'd0};

  logic zx [2], initx [2], ldx [2], zt [2], initt [2], ldt [2], zr [2], initr [2];
  logic ldr [2], zc [2], ldc [2], enc [2], s0 [2], busy [2], done [2], err [2];
  logic [15:0] vec [2];

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  series_controller u_dut16 (
    .clk(clk), .rst(rst), .start(start[0]), .co(co[0]),
    .zx(zx[0]), .initx(initx[0]), .ldx(ldx[0]), .zt(zt[0]), .initt(initt[0]), .ldt(ldt[0]),
    .zr(zr[0]), .initr(initr[0]), .ldr(ldr[0]), .zc(zc[0]), .ldc(ldc[0]), .enc(enc[0]),
    .s0(s0[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  series_controller #(.TERM_LIMIT(4), .ITER_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .start(start[1]), .co(co[1]),
    .zx(zx[1]), .initx(initx[1]), .ldx(ldx[1]), .zt(zt[1]), .initt(initt[1]), .ldt(ldt[1]),
    .zr(zr[1]), .initr(initr[1]), .ldr(ldr[1]), .zc(zc[1]), .ldc(ldc[1]), .enc(enc[1]),
    .s0(s0[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_lane
    assign vec[g] = {zx[g], initx[g], ldx[g], zt[g], initt[g], ldt[g], zr[g], initr[g],
                     ldr[g], zc[g], ldc[g], enc[g], s0[g], busy[g], done[g], err[g]};
    assign co[g]  = (co_mode[g] == 0) ? (adr[g] == 4'd15) :
                    (co_mode[g] == 1) ? 1'b0 : rnd_co[g];
  end

  // Datapath address counter, the source of co in mode 0.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst || zc[i]) adr[i] <= 4'd0;
      else if (enc[i])  adr[i] <= adr[i] + 4'd1;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) rnd_co[i] = ($urandom_range(0, 9) == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: m_rt = cycles since LOAD (-1 when not running), m_fin = 1 done / 2 abort cycle.
  int m_rt  [2] = '{-1, -1};
  int m_fin [2] = '{0, 0};
  bit m_err [2] = '{1'b0, 1'b0};

  function automatic logic [15:0] exp_vec(int rt, int fin, bit e);
    logic [15:0] v;
    v = '0;
    v[B_ERR] = e;
    if (fin == 1) begin
      v[B_DONE] = 1'b1; v[B_BUSY] = 1'b1;
    end else if (fin == 2) begin
      v[B_ZX] = 1'b1; v[B_ZT] = 1'b1; v[B_ZR] = 1'b1; v[B_ZC] = 1'b1; v[B_BUSY] = 1'b1;
    end else if (rt == 0) begin
      v[B_LDX] = 1'b1; v[B_INITT] = 1'b1; v[B_INITR] = 1'b1; v[B_ZC] = 1'b1; v[B_BUSY] = 1'b1;
    end else if (rt > 0) begin
      v[B_BUSY] = 1'b1;
      case ((rt - 1) % 3)
        0:       v[B_LDT] = 1'b1;
        1:       begin v[B_LDT] = 1'b1; v[B_S0] = 1'b1; end
        default: begin v[B_LDR] = 1'b1; v[B_ENC] = 1'b1; end
      endcase
    end
    return v;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_rt[i] = -1; m_fin[i] = 0; m_err[i] = 1'b0;
      end else if (m_fin[i] == 2) begin
        m_fin[i] = 0; m_err[i] = 1'b1;
      end else if (m_fin[i] == 1) begin
        m_fin[i] = 0;
      end else if (m_rt[i] < 0) begin
        if (start[i]) begin m_rt[i] = 0; m_err[i] = 1'b0; end
      end else if (m_rt[i] > 0 && (m_rt[i] - 1) % 3 == 2) begin
        if (co[i])                        begin m_fin[i] = 1; m_rt[i] = -1; end
        else if (m_rt[i] / 3 == lim[i])   begin m_fin[i] = 2; m_rt[i] = -1; end
        else m_rt[i] = m_rt[i] + 1;
      end else begin
        m_rt[i] = m_rt[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++)
        check($sformatf("cycle_dut%0d", i), 32'(vec[i]), 32'(exp_vec(m_rt[i], m_fin[i], m_err[i])));
    end
  end

  int dcyc, nacc, ndone, nabort, nload, ecyc, mulx_seen, done_win;
  bit errl, tmo, sent_mulc, sent_done;

  // Pulse start on lane i from an idle negedge and follow it back to idle.
  task automatic run_one(input int i, output int done_cyc, output int n_acc, output int n_done,
                         output int n_abort, output int n_load, output int end_cyc,
                         output bit err_load, output bit timeout);
    done_cyc = -1; n_acc = 0; n_done = 0; n_abort = 0; n_load = 0; end_cyc = -1;
    err_load = 1'b1; timeout = 1'b1;
    start[i] = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      start[i] = 1'b0;
      if (vec[i][B_LDX]) begin n_load++; err_load = vec[i][B_ERR]; end
      if (vec[i][B_ENC]) n_acc++;
      if (vec[i][B_ZX])  n_abort++;
      if (vec[i][B_DONE]) begin n_done++; if (done_cyc < 0) done_cyc = k; end
      if (!vec[i][B_BUSY]) begin end_cyc = k; timeout = 1'b0; break; end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("idle16_c%0d", c), 32'(vec[0]), 32'h0);
      check($sformatf("idle4_c%0d", c), 32'(vec[1]), 32'h0);
    end

    // Full run, co on the 16th ACC coinciding with the limit
    run_one(0, dcyc, nacc, ndone, nabort, nload, ecyc, errl, tmo);
    check("full_timeout", 32'(tmo), 32'd0);
    check("full_done_cycle", 32'(dcyc), 32'd50);
    check("full_busy_low_cycle", 32'(ecyc), 32'd51);
    check("full_acc_count", 32'(nacc), 32'd16);
    check("full_load_count", 32'(nload), 32'd1);
    check("full_done_count", 32'(ndone), 32'd1);
    check("full_abort_count", 32'(nabort), 32'd0);
    check("full_err", 32'(vec[0][B_ERR]), 32'd0);

    // Limit 4, co never: abort path, sticky err, cleared by next start
    run_one(1, dcyc, nacc, ndone, nabort, nload, ecyc, errl, tmo);
    check("abort_timeout", 32'(tmo), 32'd0);
    check("abort_acc_count", 32'(nacc), 32'd4);
    check("abort_pulses", 32'(nabort), 32'd1);
    check("abort_done_count", 32'(ndone), 32'd0);
    check("abort_idle_cycle", 32'(ecyc), 32'd15);
    repeat (3) @(negedge clk);
    check("abort_err_sticky", 32'(vec[1][B_ERR]), 32'd1);
    run_one(1, dcyc, nacc, ndone, nabort, nload, ecyc, errl, tmo);
    check("abort_err_cleared_at_load", 32'(errl), 32'd0);
    check("abort_err_again", 32'(vec[1][B_ERR]), 32'd1);

    // start during MULC and during DONE must be ignored
    sent_mulc = 1'b0; sent_done = 1'b0; ndone = 0; dcyc = -1; tmo = 1'b1;
    start[0] = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (!sent_mulc && vec[0][B_LDT] && vec[0][B_S0]) begin start[0] = 1'b1; sent_mulc = 1'b1; end
      if (vec[0][B_DONE]) begin
        ndone++;
        if (dcyc < 0) dcyc = k;
        if (!sent_done) begin start[0] = 1'b1; sent_done = 1'b1; end
      end
      if (!vec[0][B_BUSY]) begin tmo = 1'b0; break; end
    end
    check("ignore_timeout", 32'(tmo), 32'd0);
    check("ignore_done_cycle", 32'(dcyc), 32'd50);
    done_win = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (vec[0][B_DONE]) done_win++;
      check($sformatf("ignore_stay_idle_c%0d", c), 32'(vec[0][B_BUSY]), 32'd0);
    end
    check("ignore_done_total", 32'(ndone + done_win), 32'd1);
    run_one(0, dcyc, nacc, ndone, nabort, nload, ecyc, errl, tmo);
    check("ignore_next_start_done", 32'(dcyc), 32'd50);

    // Reset during the 7th MULX
    mulx_seen = 0;
    start[0] = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (vec[0][B_LDT] && !vec[0][B_S0]) mulx_seen++;
      if (mulx_seen == 7) break;
    end
    check("rst_mulx_reached", 32'(mulx_seen), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_outputs_zero", 32'(vec[0]), 32'h0);
    run_one(0, dcyc, nacc, ndone, nabort, nload, ecyc, errl, tmo);
    check("rst_fresh_load", 32'(nload), 32'd1);
    check("rst_fresh_done", 32'(dcyc), 32'd50);

    // Randomized traffic on both lanes, including held start and rare resets
    for (int seg = 0; seg < 12; seg++) begin
      co_mode[0] = int'($urandom_range(0, 2));
      co_mode[1] = int'($urandom_range(0, 2));
      for (int c = 0; c < 250; c++) begin
        @(negedge clk);
        rst = ($urandom_range(0, 299) == 0);
        for (int i = 0; i < 2; i++)
          start[i] = (seg % 3 == 2) ? 1'b1 : ($urandom_range(0, 4) == 0);
      end
    end
    rst = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
